// File: rtl/mem_access_if.sv
// mem_access_if: byte-wide synchronous RAM port (address, write byte/strobe, busy, read byte)
interface mem_access_if #(parameter int ADDR_W = 17) ();
  logic [ADDR_W-1:0] mem_a;
  logic [7:0] mem_dout;
  logic mem_wr;
  logic mem_busy;
  logic [7:0] mem_din;
  modport master(output mem_a, mem_dout, mem_wr, input mem_busy, mem_din);
  modport slave(input mem_a, mem_dout, mem_wr, output mem_busy, mem_din);
endinterface

// File: rtl/mem_access.sv
// mem_access: RV32I MEM stage, byte-serial loads/stores over a 1-byte RAM port with pipeline stall
// Optional MEM_MISALIGN_TRAP_EN: misaligned H/W accesses pulse misalign_o instead of touching RAM.
module mem_access #(parameter int MEM_ADDR_W = 17) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] store_data_i,
  input  logic        mem_re_i,
  input  logic        mem_we_i,
  input  logic [2:0]  funct3_i,
  mem_access_if.master m,
  output logic [4:0]  rd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        stall_req_o,
  output logic        misalign_o
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t st;
  logic [MEM_ADDR_W-1:0] a;
  logic [31:0] d, ext;
  logic [1:0] sz, k, pidx;
  logic uns, we, pend, req, ok, mis, go, issue, last, unused_hi;
  logic [3:0][7:0] b;
  assign unused_hi = ^mem_addr_i[31:MEM_ADDR_W];
  always_comb begin
    req = mem_re_i | mem_we_i;
    ok = funct3_i[1:0] != 2'b11 && (mem_we_i ? !funct3_i[2] : !(funct3_i[2] && funct3_i[1]));
`ifdef MEM_MISALIGN_TRAP_EN
    mis = (funct3_i[1:0] == 2'b01 && mem_addr_i[0]) || (funct3_i[1:0] == 2'b10 && mem_addr_i[1:0] != 2'b00);
`else
    mis = 1'b0;
`endif
    go = req && ok && !mis;
    issue = st == ISSUE && !m.mem_busy;
    last = k == {sz[1], |sz};
    ext = sz == 2'd0 ? {{24{!uns && b[0][7]}}, b[0]} :
          sz == 2'd1 ? {{16{!uns && b[1][7]}}, b[1], b[0]} : b;
    // everything is forced low while reset is asserted, including the pass-through path
    stall_req_o = rst && (st == IDLE ? go : st != DONE);
    wreg_o = rst && (st == IDLE ? wreg_i && !req : st == DONE && wreg_i && !we);
    rd_o = rst ? rd_i : '0;
    wdata_o = !rst ? '0 : st == DONE ? ext : wdata_i;
    misalign_o = rst && st == IDLE && req && ok && mis;
    m.mem_a = rst && st == ISSUE ? a + MEM_ADDR_W'(k) : '0;
    m.mem_dout = rst && st == ISSUE && we ? d[{k, 3'b000} +: 8] : '0;
    m.mem_wr = rst && issue && we;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      st <= IDLE;
      k <= '0;
      a <= '0;
      d <= '0;
      sz <= '0;
      uns <= 1'b0;
      we <= 1'b0;
      b <= '0;
      pend <= 1'b0;
      pidx <= '0;
    end else begin
      // read data returns one cycle after issue, independent of busy stalls
      pend <= issue && !we;
      pidx <= k;
      if (pend) b[pidx] <= m.mem_din;
      case (st)
        IDLE: if (go) begin
          st <= ISSUE;
          k <= '0;
          a <= mem_addr_i[MEM_ADDR_W-1:0];
          d <= store_data_i;
          sz <= funct3_i[1:0];
          uns <= funct3_i[2];
          we <= mem_we_i;
        end
        ISSUE: if (!m.mem_busy) begin
          k <= k + 2'd1;
          if (last) st <= we ? DONE : WAIT;
        end
        WAIT: st <= DONE;
        default: st <= IDLE;
      endcase
    end
endmodule
